// File: rtl/hvc007_pkg.sv
// Shared constants, key-event record and matrix index helper for the HVC-007 keyboard scanner.
// Matrix index layout is {row, column, bit}, i.e. row*8 + column*4 + bit.
package hvc007_pkg;

   localparam int NUM_ROWS  = 9;
   localparam int NUM_KEYS  = 72;
   localparam int KEY_BITS  = 7;
   localparam int EVQ_DEPTH = 4;

   localparam logic [3:0] HVC007_NO_KEY = 4'b1111;

   typedef struct packed {
      logic                pressed;
      logic [KEY_BITS-1:0] code;
   } key_evt_t;

   function automatic logic [KEY_BITS-1:0] key_index(input logic [3:0] row,
                                                      input logic       col,
                                                      input logic [1:0] bit_sel);
      return {row, col, bit_sel};
   endfunction

endpackage

// File: rtl/hvc007_key_event_fifo.sv
// Small key-event queue: DEPTH entries, head visible combinationally on pop_dat.
// Push is refused only when full and not popping; flush empties it in one cycle and drops a same-cycle push.
module hvc007_key_event_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             core_clk,
   input  logic             arst_n,
   input  logic             flush,
   input  logic             push_vld,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop_rdy,
   output logic [WIDTH-1:0] pop_dat,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop_rdy & ~empty;
   assign do_push = push_vld & (~full | do_pop);
   assign pop_dat = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge core_clk or negedge arst_n) begin
      if (!arst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Storage needs no reset: entries are only read between push and pop.
   always_ff @(posedge core_clk) begin
      if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= push_dat;
   end

endmodule

// File: rtl/hvc007_matrix_scanner.sv
// HVC-007 keyboard matrix: $4016-driven row/column scan, 72-key matrix fed by a queued key-event stream.
// Output nibble is registered one cycle behind scan/matrix state; o_key_ready drops when the queue is full.
module hvc007_matrix_scanner #(
   parameter int NUM_ROWS  = hvc007_pkg::NUM_ROWS,
   parameter int NUM_KEYS  = hvc007_pkg::NUM_KEYS,
   parameter int EVQ_DEPTH = hvc007_pkg::EVQ_DEPTH
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_ce,
   input  logic       i_wr_4016,
   input  logic [2:0] i_wr_data,
   input  logic       i_key_valid,
   input  logic [6:0] i_key_code,
   input  logic       i_key_pressed,
   output logic       o_key_ready,
   input  logic       i_release_all,
   output logic       o_bad_code,
   output logic [3:0] o_row,
   output logic       o_column,
   output logic [3:0] o_hvc007_keyboard_data
);

   import hvc007_pkg::*;

   localparam int WW = $clog2(EVQ_DEPTH + 1);

   logic                row_q;
   logic [3:0]          row_cnt_q;
   logic                col_q;
   logic                en_q;
   logic [NUM_KEYS-1:0] matrix_q;
   logic                bad_q;
   logic [3:0]          nib_q;
   logic [3:0]          nib_next;
   logic                rdy_en_q;
   logic [WW-1:0]       warm_cnt_q;
   logic                drain_en;
   logic                wr_hit;
   logic                fifo_full;
   logic                fifo_empty;
   logic                push;
   logic                pop;
   key_evt_t            push_evt;
   key_evt_t            head_evt;
   logic [6:0]          nib_idx;
   logic                head_ok;

   // row_q is the in-range flag for the current row.
   assign row_q = (row_cnt_q < 4'(NUM_ROWS));

   // After reset the producer is admitted one cycle before the drain starts; the drain
   // waits EVQ_DEPTH further cycles so a post-reset burst lands in the queue first.
   assign drain_en = (warm_cnt_q == WW'(EVQ_DEPTH));

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         rdy_en_q   <= 1'b0;
         warm_cnt_q <= '0;
      end else begin
         rdy_en_q <= 1'b1;
         if (rdy_en_q && !drain_en) warm_cnt_q <= warm_cnt_q + WW'(1);
      end
   end

   assign o_key_ready = rdy_en_q & ~fifo_full & ~i_release_all;
   assign push        = i_key_valid & o_key_ready;
   assign pop         = drain_en & ~fifo_empty & ~i_release_all;

   always_comb begin
      push_evt         = '0;
      push_evt.pressed = i_key_pressed;
      push_evt.code    = i_key_code;
   end

   hvc007_key_event_fifo #(
      .DEPTH (EVQ_DEPTH),
      .WIDTH ($bits(key_evt_t))
   ) u_evq (
      .core_clk (i_clk),
      .arst_n   (i_reset_n),
      .flush    (i_release_all),
      .push_vld (push),
      .push_dat (push_evt),
      .pop_rdy  (pop),
      .pop_dat  (head_evt),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   assign head_ok = (head_evt.code < 7'(NUM_KEYS));
   assign wr_hit  = i_wr_4016 & i_ce;

   // Row advances on the column 1->0 edge and parks at NUM_ROWS; reset_row wins.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         row_cnt_q <= '0;
         col_q     <= 1'b0;
         en_q      <= 1'b0;
      end else if (wr_hit) begin
         en_q  <= i_wr_data[2];
         col_q <= i_wr_data[1];
         if (i_wr_data[0]) begin
            row_cnt_q <= '0;
         end else if (col_q && !i_wr_data[1] && row_q) begin
            row_cnt_q <= row_cnt_q + 4'd1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         matrix_q <= '0;
         bad_q    <= 1'b0;
      end else begin
         bad_q <= pop & ~head_ok;
         if (i_release_all) begin
            matrix_q <= '0;
         end else if (pop && head_ok) begin
            matrix_q[head_evt.code] <= head_evt.pressed;
         end
      end
   end

   assign nib_idx = row_q ? key_index(row_cnt_q, col_q, 2'd0) : 7'd0;

   always_comb begin
      nib_next = HVC007_NO_KEY;
      if (!en_q) begin
         nib_next = 4'b0000;
      end else if (row_q) begin
         nib_next = ~matrix_q[nib_idx +: 4];
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         nib_q <= 4'b0000;
      end else begin
         nib_q <= nib_next;
      end
   end

   assign o_bad_code             = bad_q;
   assign o_row                  = row_cnt_q;
   assign o_column               = col_q;
   assign o_hvc007_keyboard_data = nib_q;

endmodule
